// File: rtl/regfile_multiport_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_multiport_if
//  Brief    : Read/write port bundle between decode, writeback and the file.
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_multiport_if #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2
);
    localparam int c_AW = $clog2(NUM_REGS);

    logic [NUM_RD*c_AW-1:0]   RA;
    logic [NUM_RD*DATA_W-1:0] Bus;
    logic [NUM_WR-1:0]        WrEn;
    logic [NUM_WR*c_AW-1:0]   RW;
    logic [NUM_WR*DATA_W-1:0] BusW;
    logic                     WrConflict;
    logic                     RangeErr;

    modport master (
        output RA, WrEn, RW, BusW,
        input  Bus, WrConflict, RangeErr
    );

    modport slave (
        input  RA, WrEn, RW, BusW,
        output Bus, WrConflict, RangeErr
    );
endinterface
`default_nettype wire

// File: rtl/regfile_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_multiport
//  Brief    : Multi-port register file with hardwired-zero register, bypass,
//             optional registered reads, conflict and range-error flags.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_multiport #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 3,
    parameter int NUM_WR   = 2,
    parameter int ZERO_EN  = 1,
    parameter int ZERO_REG = 31,
    parameter int BYPASS   = 1,
    parameter int READ_LAT = 0
) (
    input  logic               Clk,
    input  logic               Rst_n,
    regfile_multiport_if.slave rf
);
    localparam int              c_AW       = $clog2(NUM_REGS);
    localparam logic [c_AW:0]   c_NUM_REGS = (c_AW + 1)'(NUM_REGS);
    localparam logic [c_AW-1:0] c_ZERO_REG = c_AW'(ZERO_REG);
    localparam bit              c_ZERO_EN  = (ZERO_EN != 0);
    localparam bit              c_BYPASS   = (BYPASS != 0);

    logic [DATA_W-1:0]        r_regs   [NUM_REGS];
    logic [c_AW-1:0]          w_rdAddr [NUM_RD];
    logic [c_AW-1:0]          w_wrAddr [NUM_WR];
    logic [DATA_W-1:0]        w_wrData [NUM_WR];
    logic [DATA_W-1:0]        w_rdVal  [NUM_RD];
    logic [NUM_WR-1:0]        w_wrOk;
    logic [NUM_RD*DATA_W-1:0] w_rdFlat;
    logic                     w_conflict;
    logic                     w_rangeHit;
    logic                     r_wrConflict;
    logic                     r_rangeErr;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rdPort
        assign w_rdAddr[i]                  = rf.RA[i*c_AW +: c_AW];
        assign w_rdFlat[i*DATA_W +: DATA_W] = w_rdVal[i];
    end

    // A write port is "ok" only if it really changes storage; bypass uses the same qualifier.
    for (genvar j = 0; j < NUM_WR; j++) begin : g_wrPort
        assign w_wrAddr[j] = rf.RW[j*c_AW +: c_AW];
        assign w_wrData[j] = rf.BusW[j*DATA_W +: DATA_W];
        assign w_wrOk[j]   = rf.WrEn[j]
                           && ({1'b0, w_wrAddr[j]} < c_NUM_REGS)
                           && !(c_ZERO_EN && (w_wrAddr[j] == c_ZERO_REG));
    end

    always_comb begin
        w_conflict = 1'b0;
        w_rangeHit = 1'b0;
        for (int j = 0; j < NUM_WR; j++) begin
            if (rf.WrEn[j] && ({1'b0, w_wrAddr[j]} >= c_NUM_REGS))
                w_rangeHit = 1'b1;
            for (int k = j + 1; k < NUM_WR; k++) begin
                if (rf.WrEn[j] && rf.WrEn[k] && (w_wrAddr[j] == w_wrAddr[k]))
                    w_conflict = 1'b1;
            end
        end
        for (int i = 0; i < NUM_RD; i++) begin
            if ({1'b0, w_rdAddr[i]} >= c_NUM_REGS)
                w_rangeHit = 1'b1;
        end
    end

    // Ascending port scan: the highest matching write port overrides lower ones.
    always_comb begin
        w_rdVal = '{default: '0};
        for (int i = 0; i < NUM_RD; i++) begin
            if (!(c_ZERO_EN && (w_rdAddr[i] == c_ZERO_REG))
                && ({1'b0, w_rdAddr[i]} < c_NUM_REGS)) begin
                w_rdVal[i] = r_regs[w_rdAddr[i]];
                if (c_BYPASS) begin
                    for (int j = 0; j < NUM_WR; j++) begin
                        if (w_wrOk[j] && (w_wrAddr[j] == w_rdAddr[i]))
                            w_rdVal[i] = w_wrData[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < NUM_REGS; k++)
                r_regs[k] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (w_wrOk[j])
                    r_regs[w_wrAddr[j]] <= w_wrData[j];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_wrConflict <= 1'b0;
            r_rangeErr   <= 1'b0;
        end else begin
            r_wrConflict <= w_conflict;
            r_rangeErr   <= r_rangeErr | w_rangeHit;
        end
    end

    if (READ_LAT != 0) begin : g_regRead
        logic [NUM_RD*DATA_W-1:0] r_bus;
        always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n)
                r_bus <= '0;
            else
                r_bus <= w_rdFlat;
        end
        assign rf.Bus = r_bus;
    end else begin : g_combRead
        assign rf.Bus = w_rdFlat;
    end

    assign rf.WrConflict = r_wrConflict;
    assign rf.RangeErr   = r_rangeErr;
endmodule
`default_nettype wire

// File: tb/tb_regfile_multiport.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_multiport
//  Brief    : Three configurations driven in lockstep; scoreboard of read data.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_multiport;
    // dut 0 = A: 32 regs, zero=31, bypass, comb read
    // dut 1 = B: 24 regs, zero=0,  bypass, registered read
    // dut 2 = C: 32 regs, no zero reg, no bypass, comb read
    logic         Clk = 1'b0;
    logic         Rst_n;
    logic [14:0]  ra;
    logic [1:0]   wrEn;
    logic [9:0]   rw;
    logic [127:0] busW;
    int           cyc = 0;
    int           checks = 0;
    int           failures = 0;

    typedef struct {
        string       tag;
        int          dut;
        int          port;
        logic [63:0] exp;
        int          due;
    } sb_t;

    sb_t sbComb[$];
    sb_t sbReg[$];

    regfile_multiport_if #(.NUM_REGS(32)) ifA ();
    regfile_multiport_if #(.NUM_REGS(24)) ifB ();
    regfile_multiport_if #(.NUM_REGS(32)) ifC ();

    assign ifA.RA = ra;  assign ifA.WrEn = wrEn;  assign ifA.RW = rw;  assign ifA.BusW = busW;
    assign ifB.RA = ra;  assign ifB.WrEn = wrEn;  assign ifB.RW = rw;  assign ifB.BusW = busW;
    assign ifC.RA = ra;  assign ifC.WrEn = wrEn;  assign ifC.RW = rw;  assign ifC.BusW = busW;

    regfile_multiport #(.NUM_REGS(32), .ZERO_EN(1), .ZERO_REG(31), .BYPASS(1), .READ_LAT(0))
        dutA (.Clk(Clk), .Rst_n(Rst_n), .rf(ifA.slave));
    regfile_multiport #(.NUM_REGS(24), .ZERO_EN(1), .ZERO_REG(0), .BYPASS(1), .READ_LAT(1))
        dutB (.Clk(Clk), .Rst_n(Rst_n), .rf(ifB.slave));
    regfile_multiport #(.NUM_REGS(32), .ZERO_EN(0), .ZERO_REG(31), .BYPASS(0), .READ_LAT(0))
        dutC (.Clk(Clk), .Rst_n(Rst_n), .rf(ifC.slave));

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] busOf(input int d, input int p);
        case (d)
            0:       return ifA.Bus[p*64 +: 64];
            1:       return ifB.Bus[p*64 +: 64];
            default: return ifC.Bus[p*64 +: 64];
        endcase
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] en, input logic [4:0] w0, input logic [63:0] d0,
                         input logic [4:0] w1, input logic [63:0] d1,
                         input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] r2);
        wrEn = en;
        rw   = {w1, w0};
        busW = {d1, d0};
        ra   = {r2, r1, r0};
    endtask

    task automatic pushExp(input int d, input int p, input logic [63:0] v, input string tag);
        sb_t e;
        e.tag  = tag;
        e.dut  = d;
        e.port = p;
        e.exp  = v;
        e.due  = (d == 1) ? cyc + 1 : cyc;
        if (d == 1) sbReg.push_back(e);
        else        sbComb.push_back(e);
    endtask

    task automatic pushAll(input int p, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] c, input string tag);
        pushExp(0, p, a, tag);
        pushExp(1, p, b, tag);
        pushExp(2, p, c, tag);
    endtask

    task automatic test_reset();
        sb_t e;
        logic [63:0] got;
        logic [2:0] fl;
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd3, 5'd5, 5'd7);
        for (int c = 0; c < 2; c++) begin
            if (c == 0)
                for (int p = 0; p < 3; p++) pushAll(p, 64'd0, 64'd0, 64'd0, "reset_read");
            @(negedge Clk);
            while (sbComb.size() > 0 || (sbReg.size() > 0 && sbReg[0].due <= cyc)) begin
                if (sbComb.size() > 0) e = sbComb.pop_front();
                else                   e = sbReg.pop_front();
                got = busOf(e.dut, e.port);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
                end
            end
            fl = {ifA.WrConflict, ifB.WrConflict, ifC.WrConflict};
            checks++;
            if (fl !== 3'b000) begin
                failures++;
                $display("FAIL reset_conflict: got %b expected 000", fl);
            end
            fl = {ifA.RangeErr, ifB.RangeErr, ifC.RangeErr};
            checks++;
            if (fl !== 3'b000) begin
                failures++;
                $display("FAIL reset_rangeerr: got %b expected 000", fl);
            end
            if (c == 0) Rst_n = 1'b1;
            tick();
        end
    endtask

    task automatic test_write_read();
        sb_t e;
        logic [63:0] got;
        logic [63:0] vD = 64'hDEAD_BEEF_0123_4567;
        logic [63:0] v6 = 64'h1111_2222_3333_4444;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: begin
                    drive(2'b01, 5'd5, vD, 5'd0, 64'd0, 5'd0, 5'd5, 5'd0);
                    pushAll(1, vD, vD, 64'd0, "wr_rd_bypass");
                end
                1: begin
                    drive(2'b10, 5'd0, 64'd0, 5'd6, v6, 5'd6, 5'd5, 5'd6);
                    pushAll(0, v6, v6, 64'd0, "wr_rd_port1_bypass");
                    pushAll(1, vD, vD, vD, "wr_rd_stored");
                    pushAll(2, v6, v6, 64'd0, "wr_rd_port1_bypass_rd2");
                end
                default: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd6, 5'd5, 5'd0);
                    pushAll(0, v6, v6, v6, "wr_rd_port1_stored");
                    pushAll(1, vD, vD, vD, "wr_rd_hold");
                end
            endcase
            @(negedge Clk);
            while (sbComb.size() > 0 || (sbReg.size() > 0 && sbReg[0].due <= cyc)) begin
                if (sbComb.size() > 0) e = sbComb.pop_front();
                else                   e = sbReg.pop_front();
                got = busOf(e.dut, e.port);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
                end
            end
            tick();
        end
    endtask

    task automatic test_conflict();
        sb_t e;
        logic [63:0] got;
        logic [2:0] fl;
        logic [2:0] expFl;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin
                    drive(2'b11, 5'd7, 64'd1, 5'd7, 64'd2, 5'd7, 5'd0, 5'd0);
                    pushAll(0, 64'd2, 64'd2, 64'd0, "conflict_bypass_high");
                end
                1: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd7, 5'd0, 5'd0);
                    pushAll(0, 64'd2, 64'd2, 64'd2, "conflict_winner");
                end
                2: begin
                    drive(2'b01, 5'd10, 64'd3, 5'd10, 64'd4, 5'd10, 5'd0, 5'd0);
                    pushAll(0, 64'd3, 64'd3, 64'd0, "single_en_bypass");
                end
                default: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd10, 5'd0, 5'd0);
                    pushAll(0, 64'd3, 64'd3, 64'd3, "single_en_stored");
                end
            endcase
            expFl = (c == 1) ? 3'b111 : 3'b000;
            @(negedge Clk);
            while (sbComb.size() > 0 || (sbReg.size() > 0 && sbReg[0].due <= cyc)) begin
                if (sbComb.size() > 0) e = sbComb.pop_front();
                else                   e = sbReg.pop_front();
                got = busOf(e.dut, e.port);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
                end
            end
            fl = {ifA.WrConflict, ifB.WrConflict, ifC.WrConflict};
            checks++;
            if (fl !== expFl) begin
                failures++;
                $display("FAIL wrconflict cycle%0d: got %b expected %b", c, fl, expFl);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        sb_t e;
        logic [63:0] got;
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: drive(2'b01, 5'd9, 64'hAA, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
                1: begin
                    drive(2'b01, 5'd9, 64'h55, 5'd0, 64'd0, 5'd9, 5'd0, 5'd0);
                    pushAll(0, 64'h55, 64'h55, 64'hAA, "bypass_same_cycle");
                end
                default: begin
                    drive(2'b00, 5'd9, 64'h77, 5'd0, 64'd0, 5'd9, 5'd0, 5'd0);
                    pushAll(0, 64'h55, 64'h55, 64'h55, "bypass_disabled_write");
                end
            endcase
            @(negedge Clk);
            while (sbComb.size() > 0 || (sbReg.size() > 0 && sbReg[0].due <= cyc)) begin
                if (sbComb.size() > 0) e = sbComb.pop_front();
                else                   e = sbReg.pop_front();
                got = busOf(e.dut, e.port);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
                end
            end
            tick();
        end
    endtask

    task automatic test_range();
        sb_t e;
        logic [63:0] got;
        logic [2:0] fl;
        logic [2:0] expFl;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd26, 5'd0, 5'd0);
                    pushAll(0, 64'd0, 64'd0, 64'd0, "range_read");
                end
                1: begin
                    drive(2'b01, 5'd26, 64'h99, 5'd0, 64'd0, 5'd26, 5'd0, 5'd0);
                    pushAll(0, 64'h99, 64'd0, 64'd0, "range_no_bypass");
                end
                2: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd26, 5'd0, 5'd0);
                    pushAll(0, 64'h99, 64'd0, 64'h99, "range_after_write");
                end
                default: drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
            endcase
            expFl = (c == 0) ? 3'b000 : 3'b010;
            @(negedge Clk);
            while (sbComb.size() > 0 || (sbReg.size() > 0 && sbReg[0].due <= cyc)) begin
                if (sbComb.size() > 0) e = sbComb.pop_front();
                else                   e = sbReg.pop_front();
                got = busOf(e.dut, e.port);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
                end
            end
            fl = {ifA.RangeErr, ifB.RangeErr, ifC.RangeErr};
            checks++;
            if (fl !== expFl) begin
                failures++;
                $display("FAIL rangeerr cycle%0d: got %b expected %b", c, fl, expFl);
            end
            tick();
        end
    endtask

    task automatic test_zero_reg();
        sb_t e;
        logic [63:0] got;
        logic [63:0] ones = '1;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin
                    drive(2'b01, 5'd31, ones, 5'd0, 64'd0, 5'd31, 5'd0, 5'd0);
                    pushAll(0, 64'd0, 64'd0, 64'd0, "zero_write_cycle");
                end
                1: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd31, 5'd0, 5'd0);
                    pushAll(0, 64'd0, 64'd0, ones, "zero_reg31");
                end
                2: begin
                    drive(2'b10, 5'd0, 64'd0, 5'd0, 64'hCAFE, 5'd0, 5'd0, 5'd0);
                    pushAll(1, 64'hCAFE, 64'd0, 64'd0, "zero_reg0_write");
                end
                default: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
                    pushAll(1, 64'hCAFE, 64'd0, 64'hCAFE, "zero_reg0_stored");
                end
            endcase
            @(negedge Clk);
            while (sbComb.size() > 0 || (sbReg.size() > 0 && sbReg[0].due <= cyc)) begin
                if (sbComb.size() > 0) e = sbComb.pop_front();
                else                   e = sbReg.pop_front();
                got = busOf(e.dut, e.port);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        sb_t e;
        logic [63:0] got;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: begin
                    drive(2'b11, 5'd12, 64'hA1, 5'd13, 64'hB1, 5'd12, 5'd13, 5'd12);
                    pushAll(0, 64'hA1, 64'hA1, 64'd0, "b2b_c0_r12");
                    pushAll(1, 64'hB1, 64'hB1, 64'd0, "b2b_c0_r13");
                    pushAll(2, 64'hA1, 64'hA1, 64'd0, "b2b_c0_r12b");
                end
                1: begin
                    drive(2'b11, 5'd13, 64'hA2, 5'd12, 64'hB2, 5'd12, 5'd13, 5'd14);
                    pushAll(0, 64'hB2, 64'hB2, 64'hA1, "b2b_c1_r12");
                    pushAll(1, 64'hA2, 64'hA2, 64'hB1, "b2b_c1_r13");
                    pushAll(2, 64'd0, 64'd0, 64'd0, "b2b_c1_r14");
                end
                2: begin
                    drive(2'b01, 5'd14, 64'hC3, 5'd0, 64'd0, 5'd12, 5'd13, 5'd14);
                    pushAll(0, 64'hB2, 64'hB2, 64'hB2, "b2b_c2_r12");
                    pushAll(1, 64'hA2, 64'hA2, 64'hA2, "b2b_c2_r13");
                    pushAll(2, 64'hC3, 64'hC3, 64'd0, "b2b_c2_r14");
                end
                default: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd12, 5'd13, 5'd14);
                    pushAll(2, 64'hC3, 64'hC3, 64'hC3, "b2b_c3_r14");
                end
            endcase
            @(negedge Clk);
            while (sbComb.size() > 0 || (sbReg.size() > 0 && sbReg[0].due <= cyc)) begin
                if (sbComb.size() > 0) e = sbComb.pop_front();
                else                   e = sbReg.pop_front();
                got = busOf(e.dut, e.port);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
                end
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        sb_t e;
        logic [63:0] got;
        logic [2:0] fl;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) begin
                drive(2'b11, 5'd3, 64'd5, 5'd3, 64'd6, 5'd3, 5'd0, 5'd0);
                pushAll(0, 64'd6, 64'd6, 64'd0, "pre_reset_bypass");
            end else begin
                drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd3, 5'd0, 5'd0);
                pushExp(0, 0, 64'd6, "pre_reset_stored");
                pushExp(2, 0, 64'd6, "pre_reset_stored");
            end
            @(negedge Clk);
            while (sbComb.size() > 0 || (sbReg.size() > 0 && sbReg[0].due <= cyc)) begin
                if (sbComb.size() > 0) e = sbComb.pop_front();
                else                   e = sbReg.pop_front();
                got = busOf(e.dut, e.port);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
                end
            end
            if (c == 0) tick();
        end
        // Mid-cycle reset: everything must clear before the next clock edge.
        #2;
        Rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            got = busOf(d, 0);
            checks++;
            if (got !== 64'd0) begin
                failures++;
                $display("FAIL async_reset_bus dut%0d: got %h expected 0", d, got);
            end
        end
        fl = {ifA.WrConflict, ifB.WrConflict, ifC.WrConflict};
        checks++;
        if (fl !== 3'b000) begin
            failures++;
            $display("FAIL async_reset_conflict: got %b expected 000", fl);
        end
        fl = {ifA.RangeErr, ifB.RangeErr, ifC.RangeErr};
        checks++;
        if (fl !== 3'b000) begin
            failures++;
            $display("FAIL async_reset_rangeerr: got %b expected 000", fl);
        end
        drive(2'b01, 5'd4, 64'hEE, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        tick();
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        for (int c = 0; c < 3; c++) begin
            case (c)
                0: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd4, 5'd0, 5'd0);
                    pushAll(0, 64'd0, 64'd0, 64'd0, "write_during_reset_lost");
                end
                1: begin
                    drive(2'b01, 5'd4, 64'h1234, 5'd0, 64'd0, 5'd0, 5'd4, 5'd0);
                    pushAll(1, 64'h1234, 64'h1234, 64'd0, "first_write_after_reset");
                end
                default: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd4, 5'd0);
                    pushAll(1, 64'h1234, 64'h1234, 64'h1234, "first_write_stored");
                end
            endcase
            @(negedge Clk);
            while (sbComb.size() > 0 || (sbReg.size() > 0 && sbReg[0].due <= cyc)) begin
                if (sbComb.size() > 0) e = sbComb.pop_front();
                else                   e = sbReg.pop_front();
                got = busOf(e.dut, e.port);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
                end
            end
            tick();
        end
    endtask

    task automatic test_range_write();
        sb_t e;
        logic [63:0] got;
        logic [2:0] fl;
        logic [2:0] expFl;
        for (int c = 0; c < 4; c++) begin
            case (c)
                0: drive(2'b00, 5'd27, 64'd5, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
                1: drive(2'b01, 5'd27, 64'd5, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
                2: begin
                    drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
                    pushAll(2, 64'd0, 64'd0, 64'd0, "unused_port_idle");
                end
                default: drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
            endcase
            expFl = (c >= 2) ? 3'b010 : 3'b000;
            @(negedge Clk);
            while (sbComb.size() > 0 || (sbReg.size() > 0 && sbReg[0].due <= cyc)) begin
                if (sbComb.size() > 0) e = sbComb.pop_front();
                else                   e = sbReg.pop_front();
                got = busOf(e.dut, e.port);
                checks++;
                if (got !== e.exp) begin
                    failures++;
                    $display("FAIL %s dut%0d port%0d: got %h expected %h", e.tag, e.dut, e.port, got, e.exp);
                end
            end
            fl = {ifA.RangeErr, ifB.RangeErr, ifC.RangeErr};
            checks++;
            if (fl !== expFl) begin
                failures++;
                $display("FAIL range_write cycle%0d: got %b expected %b", c, fl, expFl);
            end
            tick();
        end
    endtask

    initial begin
        Rst_n = 1'b0;
        drive(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) tick();
        test_reset();
        test_write_read();
        test_conflict();
        test_bypass();
        test_range();
        test_zero_reg();
        test_back_to_back();
        test_async_reset();
        test_range_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
